// File: rtl/burst_serial_slave.sv
// burst_serial_slave
//   Bit-serial bus slave with an on-chip block RAM. A master shifts in an
//   address (MSB first), an optional burst-length field and, for writes, the
//   data words. Reads are split: the slave raises hold while it waits out the
//   programmable latency and the bus grant, then returns each word MSB first.
//
// Optional feature macro: SLAVE_ERR_EN
//   Defined   -> adds the err output; out-of-range addresses drop writes,
//                read as zero and pulse err.
//   Undefined -> no err port; addresses alias modulo MEM_DEPTH.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-low reset
//   validIn      master presents a valid serial bit this cycle
//   wren         1=write, 0=read (start cycle only)
//   Address      serial address bits, then serial burst-length bits
//   DataIn       serial write-data bits
//   BurstEn      start cycle only: a burst-length field follows the address
//   BusAvailable arbiter grants the bus for read-data return
//   ready        slave accepts serial bits
//   validOut     DataOut carries a read-data bit
//   hold         read split in progress (latency or grant pending)
//   DataOut      serial read data, MSB first
//   state_out    current FSM state (debug)
//   err          (SLAVE_ERR_EN only) out-of-range beat in WCOMMIT/RFETCH
module burst_serial_slave #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int MEM_DEPTH  = 2048,
  parameter int READ_DELAY = 20,
  parameter int BN         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       validIn,
  input  logic       wren,
  input  logic       Address,
  input  logic       DataIn,
  input  logic       BurstEn,
  input  logic       BusAvailable,
  output logic       ready,
  output logic       validOut,
  output logic       hold,
  output logic       DataOut,
  output logic [3:0] state_out
`ifdef SLAVE_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int MAX_BITS = (ADDR_W > DATA_W) ? ((ADDR_W > BN) ? ADDR_W : BN)
                                              : ((DATA_W > BN) ? DATA_W : BN);
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int WAIT_W   = $clog2(READ_DELAY + 1);

  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  BLEN_LAST = CNT_W'(BN - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(READ_DELAY);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [BN:0]       BEATS_ONE = (BN + 1)'(1);
  localparam logic [MEM_AW-1:0] IDX_ONE   = MEM_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_BLEN    = 3'd2,
    S_WDATA   = 3'd3,
    S_WCOMMIT = 3'd4,
    S_RWAIT   = 3'd5,
    S_RFETCH  = 3'd6,
    S_RSHIFT  = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_inc, addr_shift;
  logic [BN-1:0]       blen_q, blen_d, blen_shift;
  logic [BN:0]         beats_q, beats_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                wr_q, wr_d;
  logic                burst_q, burst_d;
  logic [MEM_AW-1:0]   mem_idx;
  logic                mem_we;
  logic                addr_oob;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];

`ifdef SLAVE_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_X = MEM_DEPTH[ADDR_W:0];
  assign addr_oob = ({1'b0, addr_q} >= DEPTH_X);
  assign err      = addr_oob && ((state_q == S_WCOMMIT) || (state_q == S_RFETCH));
`else
  assign addr_oob = 1'b0;
`endif

  // Only the BRAM index bits count; upper address bits ride along so an
  // out-of-range burst stays out of range.
  always_comb begin
    addr_inc = addr_q;
    addr_inc[MEM_AW-1:0] = addr_q[MEM_AW-1:0] + IDX_ONE;
  end

  assign addr_shift = (addr_q << 1) | ADDR_W'(Address);
  assign blen_shift = (blen_q << 1) | BN'(Address);

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    blen_d   = blen_q;
    beats_d  = beats_q;
    bitcnt_d = bitcnt_q;
    wait_d   = wait_q;
    wdata_d  = wdata_q;
    shreg_d  = shreg_q;
    wr_d     = wr_q;
    burst_d  = burst_q;

    case (state_q)
      S_IDLE: begin
        if (validIn) begin
          // Start cycle: the first address bit is already on the wire.
          wr_d     = wren;
          burst_d  = BurstEn;
          addr_d   = ADDR_W'(Address);
          bitcnt_d = CNT_ONE;
          blen_d   = '0;
          beats_d  = BEATS_ONE;
          wait_d   = '0;
          wdata_d  = '0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (validIn) begin
          addr_d = addr_shift;
          if (bitcnt_q == ADDR_LAST) begin
            bitcnt_d = '0;
            wait_d   = '0;
            if (burst_q) begin
              state_d = S_BLEN;
            end else begin
              beats_d = BEATS_ONE;
              state_d = wr_q ? S_WDATA : S_RWAIT;
            end
          end else begin
            bitcnt_d = bitcnt_q + CNT_ONE;
          end
        end
      end

      S_BLEN: begin
        if (validIn) begin
          blen_d = blen_shift;
          if (bitcnt_q == BLEN_LAST) begin
            bitcnt_d = '0;
            wait_d   = '0;
            beats_d  = {1'b0, blen_shift} + BEATS_ONE;
            state_d  = wr_q ? S_WDATA : S_RWAIT;
          end else begin
            bitcnt_d = bitcnt_q + CNT_ONE;
          end
        end
      end

      S_WDATA: begin
        if (validIn) begin
          wdata_d = {wdata_q[DATA_W-2:0], DataIn};
          if (bitcnt_q == DATA_LAST) begin
            bitcnt_d = '0;
            state_d  = S_WCOMMIT;
          end else begin
            bitcnt_d = bitcnt_q + CNT_ONE;
          end
        end
      end

      S_WCOMMIT: begin
        addr_d  = addr_inc;
        beats_d = beats_q - BEATS_ONE;
        state_d = (beats_q == BEATS_ONE) ? S_IDLE : S_WDATA;
      end

      S_RWAIT: begin
        if (wait_q != WAIT_SAT) begin
          wait_d = wait_q + WAIT_ONE;
        end
        if ((wait_q >= WAIT_SAT) && BusAvailable) begin
          state_d = S_RFETCH;
        end
      end

      S_RFETCH: begin
        // rdata_q already holds mem[addr_q]: the address has been stable
        // for at least one cycle before every RFETCH.
        shreg_d  = addr_oob ? '0 : rdata_q;
        addr_d   = addr_inc;
        beats_d  = beats_q - BEATS_ONE;
        bitcnt_d = '0;
        state_d  = S_RSHIFT;
      end

      S_RSHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (bitcnt_q == DATA_LAST) begin
          bitcnt_d = '0;
          if (beats_q != '0) begin
            // Going back to RWAIT keeps the saturated latency counter, so
            // only the grant is awaited.
            state_d = BusAvailable ? S_RFETCH : S_RWAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      bitcnt_q <= '0;
      wait_q   <= '0;
      wdata_q  <= '0;
      shreg_q  <= '0;
      wr_q     <= 1'b0;
      burst_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      bitcnt_q <= bitcnt_d;
      wait_q   <= wait_d;
      wdata_q  <= wdata_d;
      shreg_q  <= shreg_d;
      wr_q     <= wr_d;
      burst_q  <= burst_d;
    end
  end

  // Block RAM: contents survive reset; a reset on the commit edge drops the beat.
  assign mem_idx = addr_q[MEM_AW-1:0];
  assign mem_we  = (state_q == S_WCOMMIT) && !addr_oob && reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
    rdata_q <= mem[mem_idx];
  end

  assign ready     = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                     (state_q == S_BLEN) || (state_q == S_WDATA);
  assign hold      = (state_q == S_RWAIT);
  assign validOut  = (state_q == S_RSHIFT);
  assign DataOut   = validOut & shreg_q[DATA_W-1];
  assign state_out = {1'b0, state_q};

endmodule

// File: tb/tb_burst_serial_slave.sv
// tb_burst_serial_slave
//   Drives serial write/read transactions into burst_serial_slave and checks
//   read data, read timing, handshake outputs and reset behaviour against a
//   word-array reference model. Prints one line per transaction.
module tb_burst_serial_slave;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;
  localparam int RD    = 20;
  localparam int BNW   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       validIn;
  logic       wren;
  logic       Address;
  logic       DataIn;
  logic       BurstEn;
  logic       BusAvailable;
  logic       ready;
  logic       validOut;
  logic       hold;
  logic       DataOut;
  logic [3:0] state_out;
`ifdef SLAVE_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] wbuf [8];

  always #5 clk = ~clk;

  burst_serial_slave #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .READ_DELAY(RD), .BN(BNW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .validIn(validIn),
    .wren(wren),
    .Address(Address),
    .DataIn(DataIn),
    .BurstEn(BurstEn),
    .BusAvailable(BusAvailable),
    .ready(ready),
    .validOut(validOut),
    .hold(hold),
    .DataOut(DataOut),
    .state_out(state_out)
`ifdef SLAVE_ERR_EN
    ,
    .err(err)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model helpers: low 11 bits wrap, upper bit is kept.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    r[10:0] = a[10:0] + 11'd1;
    return r;
  endfunction

  function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef SLAVE_ERR_EN
    return (int'(a) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (is_oob(a)) return '0;
    return model_mem[a[10:0]];
  endfunction

  task automatic send_bit(input logic abit, input logic dbit, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (g) begin
      validIn = 1'b0;
      Address = 1'($urandom);
      DataIn  = 1'($urandom);
      step();
    end
    validIn = 1'b1;
    Address = abit;
    DataIn  = dbit;
    step();
    validIn = 1'b0;
  endtask

  task automatic send_header(input logic [AW-1:0] a, input logic wr, input int nbeats,
                             input bit burst, input int gapmax);
    logic [BNW-1:0] field;
    field   = BNW'(nbeats - 1);
    validIn = 1'b1;
    wren    = wr;
    BurstEn = burst;
    Address = a[AW-1];
    DataIn  = 1'($urandom);
    step();
    validIn = 1'b0;
    // Only the start cycle may matter for these.
    wren    = 1'($urandom);
    BurstEn = 1'($urandom);
    for (int i = AW - 2; i >= 0; i--) send_bit(a[i], 1'($urandom), gapmax);
    if (burst) begin
      for (int i = BNW - 1; i >= 0; i--) send_bit(field[i], 1'($urandom), gapmax);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int nbeats, input bit burst, input int gapmax);
    logic [AW-1:0] cur;
    cur = a;
    $display("WR addr=%03h beats=%0d burst=%0d gap=%0d data0=%02h", a, nbeats, burst, gapmax, wbuf[0]);
    send_header(a, 1'b1, nbeats, burst, gapmax);
    for (int b = 0; b < nbeats; b++) begin
      for (int i = DW - 1; i >= 0; i--) send_bit(1'($urandom), wbuf[b][i], gapmax);
      check_val("wcommit_state", 32'(state_out), 32'd4);
      check_val("wcommit_ready", 32'(ready), 32'd0);
`ifdef SLAVE_ERR_EN
      check_val("wcommit_err", 32'(err), 32'(is_oob(cur)));
`endif
      if (!is_oob(cur)) model_mem[cur[10:0]] = wbuf[b];
      step();
      check_val("wpost_state", 32'(state_out), (b == nbeats - 1) ? 32'd0 : 32'd3);
      cur = next_addr(cur);
    end
  endtask

  // ba_mode 0: BusAvailable=1 from loop cycle grant_at on; 1: random grant.
  task automatic do_read(input logic [AW-1:0] a, input int nbeats, input bit burst, input int gapmax,
                         input bit ba_mode, input int grant_at);
    int            cyc, beat, bitn, exp_start, arm_from;
    bit            in_wait, waiting, hold_ok, run_ok;
    logic [DW-1:0] word;
    logic [AW-1:0] cur;
    logic          ba;
    $display("RD addr=%03h beats=%0d burst=%0d gap=%0d ba_mode=%0d grant_at=%0d",
             a, nbeats, burst, gapmax, ba_mode, grant_at);
    send_header(a, 1'b0, nbeats, burst, gapmax);
    cyc = 0; beat = 0; bitn = 0; exp_start = -1; arm_from = RD;
    in_wait = 1'b1; waiting = 1'b1; hold_ok = 1'b1; run_ok = 1'b1;
    word = '0; cur = a;
    while (beat < nbeats && cyc < 2000) begin
      if (hold !== in_wait) hold_ok = 1'b0;
`ifdef SLAVE_ERR_EN
      if (exp_start >= 0 && cyc == exp_start - 1) check_val("rfetch_err", 32'(err), 32'(is_oob(cur)));
`endif
      if (validOut === 1'b1) begin
        if (bitn == 0) check_val("rd_start_cycle", 32'(cyc), 32'(exp_start));
        word = {word[DW-2:0], DataOut};
        bitn++;
        if (bitn == DW) begin
          check_val("rd_data", 32'(word), 32'(model_read(cur)));
          cur  = next_addr(cur);
          beat++;
          bitn = 0;
          if (beat < nbeats) begin
            waiting   = 1'b1;
            arm_from  = cyc;
            exp_start = -1;
          end
        end
      end else if (bitn != 0) begin
        run_ok = 1'b0;
      end
      if (beat == nbeats) break;
      ba = ba_mode ? ($urandom_range(0, 3) != 0) : (cyc >= grant_at);
      BusAvailable = ba;
      if (waiting && cyc >= arm_from) begin
        if (ba) begin
          exp_start = cyc + 2;
          waiting   = 1'b0;
          in_wait   = 1'b0;
        end else begin
          in_wait = 1'b1;
        end
      end
      step();
      cyc++;
    end
    check_val("rd_beats_done", 32'(beat), 32'(nbeats));
    check_val("rd_hold_profile", 32'(hold_ok), 32'd1);
    check_val("rd_valid_runs", 32'(run_ok), 32'd1);
    BusAvailable = 1'($urandom);
    step();
    check_val("rd_end_valid", 32'(validOut), 32'd0);
    check_val("rd_end_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    int            nb;
    bit            bu;

    reset = 1'b0; validIn = 1'b0; wren = 1'b0; Address = 1'b0;
    DataIn = 1'b0; BurstEn = 1'b0; BusAvailable = 1'b0;
    repeat (3) step();
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_validOut", 32'(validOut), 32'd0);
    check_val("rst_hold", 32'(hold), 32'd0);
    check_val("rst_DataOut", 32'(DataOut), 32'd0);
    check_val("rst_state", 32'(state_out), 32'd0);
`ifdef SLAVE_ERR_EN
    check_val("rst_err", 32'(err), 32'd0);
`endif
    reset = 1'b1;
    step();

    // Single write then single read, grant already present
    wbuf[0] = 8'hA5;
    do_write(12'h012, 1, 1'b0, 0);
    do_read(12'h012, 1, 1'b0, 0, 1'b0, 0);

    // Burst across the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(12'h7FE, 4, 1'b1, 0);
    do_read(12'h7FE, 4, 1'b1, 0, 1'b0, 0);
    do_read(12'h000, 1, 1'b0, 0, 1'b0, 0);

    // Late grant
    do_read(12'h012, 1, 1'b0, 0, 1'b0, 40);

    // Stalls mid-address and mid-data
    wbuf[0] = 8'h00;
    do_write(12'h012, 1, 1'b0, 0);
    wbuf[0] = 8'hA5;
    do_write(12'h012, 1, 1'b0, 5);
    do_read(12'h012, 1, 1'b0, 5, 1'b0, 0);

    // Reset in the middle of a write data beat
    $display("WR addr=012 beats=1 aborted by reset");
    send_header(12'h012, 1'b1, 1, 1'b0, 0);
    for (int i = 7; i >= 4; i--) send_bit(1'b0, i[0], 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_val("midrst_state", 32'(state_out), 32'd0);
    check_val("midrst_ready", 32'(ready), 32'd1);
    check_val("midrst_hold", 32'(hold), 32'd0);
    check_val("midrst_validOut", 32'(validOut), 32'd0);
    step();
    do_read(12'h012, 1, 1'b0, 0, 1'b0, 0);
    wbuf[0] = 8'h5A;
    do_write(12'h013, 1, 1'b0, 0);
    do_read(12'h013, 1, 1'b0, 0, 1'b0, 0);

`ifdef SLAVE_ERR_EN
    wbuf[0] = 8'h77;
    do_write(12'h100, 1, 1'b0, 0);
    wbuf[0] = 8'h3C;
    do_write(12'h900, 1, 1'b0, 0);
    do_read(12'h100, 1, 1'b0, 0, 1'b0, 0);
    do_read(12'h900, 1, 1'b0, 0, 1'b0, 0);
`endif

    // Fill the random-test window 0x7E0..0x027 (wrapping)
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 8; b++) wbuf[b] = 8'($urandom);
      ra = 12'h7E0;
      for (int s = 0; s < 8 * k; s++) ra = next_addr(ra);
      do_write(ra, 8, 1'b1, 0);
    end

    // Randomized mix; bit 11 exercises aliasing (or the error path)
    for (int n = 0; n < 40; n++) begin
      ra = 12'h7E0;
      for (int s = int'($urandom_range(0, 63)); s > 0; s--) ra = next_addr(ra);
      ra[11] = 1'($urandom);
      nb = int'($urandom_range(1, 8));
      bu = (nb > 1) ? 1'b1 : 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 8; b++) wbuf[b] = 8'($urandom);
        do_write(ra, nb, bu, (n % 3 == 0) ? 2 : 0);
      end else begin
        do_read(ra, nb, bu, (n % 3 == 1) ? 2 : 0, 1'($urandom), int'($urandom_range(0, 30)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
